// File: rtl/uart_msg_streamer.sv
// ---------------------------------------------------------------------------
// uart_msg_streamer
//
// Streams a fixed ASCII template, one byte at a time, to a uart_tx over a
// valid/ready byte interface. A window of the template is overwritten with the
// uppercase hexadecimal rendering of a live input value. That value is
// captured once at the start of each message, so a changing input cannot
// tear a message in flight.
//
// Messages are started by a periodic tick, an external trigger, or both.
// One request arriving while a message is in progress is remembered and is
// served right after the current message. Any further request in that time
// is dropped and latches the sticky overrun flag.
//
// Parameters
//   PERIOD_CYCLES : clk cycles between periodic ticks (>= 2)
//   MSG_LEN       : template length in bytes (2..64)
//   TEXT          : template, byte 0 in the most significant byte, sent first
//   FIELD_POS     : index of the first hex digit in the template
//   FIELD_DIGITS  : number of hex digits (FIELD_POS+FIELD_DIGITS <= MSG_LEN)
//
// Ports
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   periodic_en   : enables the periodic tick timer
//   trigger       : single-cycle send request
//   value         : value rendered into the hex field
//   tx_data       : byte presented to uart_tx
//   tx_data_valid : tx_data holds a byte to transfer
//   tx_data_ready : uart_tx can accept a byte
//   busy          : a message is in progress (LOAD through DONE)
//   msg_done      : one-cycle pulse after the last byte has been accepted
//   overrun       : sticky, a request was dropped
//   msg_count     : completed messages, wraps 65535 -> 0
// ---------------------------------------------------------------------------
module uart_msg_streamer #(
    parameter int                   PERIOD_CYCLES = 27_000_000,
    parameter int                   MSG_LEN       = 16,
    parameter logic [MSG_LEN*8-1:0] TEXT          = {"Counter 0x????", 8'h0D, 8'h0A},
    parameter int                   FIELD_POS     = 10,
    parameter int                   FIELD_DIGITS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      periodic_en,
    input  logic                      trigger,
    input  logic [4*FIELD_DIGITS-1:0] value,
    output logic [7:0]                tx_data,
    output logic                      tx_data_valid,
    input  logic                      tx_data_ready,
    output logic                      busy,
    output logic                      msg_done,
    output logic                      overrun,
    output logic [15:0]               msg_count
);

    localparam int VAL_W = 4 * FIELD_DIGITS;
    localparam int IDX_W = $clog2(MSG_LEN);
    localparam int TMR_W = $clog2(PERIOD_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
    localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_HOLD,
        S_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Registers and wires
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [IDX_W-1:0]   r_idx;
    logic [VAL_W-1:0]   r_snap;
    logic               r_pending;
    logic               r_overrun;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic [15:0]        r_count;

    logic               w_tick;
    logic               w_req;
    logic [VAL_W-1:0]   w_snap_src;
    logic [7:0]         w_msg [MSG_LEN];
    logic [IDX_W-1:0]   w_idx_inc;
    logic [IDX_W-1:0]   w_next_idx;
    logic [7:0]         w_next_byte;

    // -----------------------------------------------------------------------
    // Hex digit encoding: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    // -----------------------------------------------------------------------
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) begin
            c = 8'h30 + {4'h0, n};
        end else begin
            c = 8'h37 + {4'h0, n};
        end
        return c;
    endfunction

    // -----------------------------------------------------------------------
    // Periodic tick timer. Held at zero while disabled so that enabling it
    // always yields a full period before the first tick.
    // -----------------------------------------------------------------------
    assign w_tick = periodic_en && (r_timer == LAST_TMR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (!periodic_en || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // A tick and a trigger in the same cycle are one request.
    assign w_req = w_tick | trigger;

    // -----------------------------------------------------------------------
    // Message rendering. In LOAD the snapshot register is only being written,
    // so byte 0 is rendered from the live input that the snapshot captures
    // in that same cycle; afterwards the snapshot register is used.
    // -----------------------------------------------------------------------
    assign w_snap_src = (r_state == S_LOAD) ? value : r_snap;

    for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_msg
        if (gi >= FIELD_POS && gi < FIELD_POS + FIELD_DIGITS) begin : g_field
            // Most significant nibble goes into the lowest field byte.
            assign w_msg[gi] = hex_char(
                w_snap_src[(FIELD_DIGITS - 1 - (gi - FIELD_POS)) * 4 +: 4]);
        end else begin : g_text
            assign w_msg[gi] = TEXT[(MSG_LEN - 1 - gi) * 8 +: 8];
        end
    end

    // Index of the byte to be loaded into the output register on the next
    // transition into SEND: byte 0 from LOAD, the following byte from HOLD.
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_next_idx  = (r_state == S_LOAD) ? '0 : w_idx_inc;
    assign w_next_byte = w_msg[w_next_idx];

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_snap    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= 16'h0000;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_req || r_pending) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        // When a buffered request is being served and a new
                        // one arrives in the same cycle, the new one takes
                        // the buffer slot instead of being lost.
                        r_pending <= r_pending & w_req;
                    end
                end

                S_LOAD: begin
                    r_snap  <= value;
                    r_idx   <= '0;
                    r_data  <= w_next_byte;
                    r_valid <= 1'b1;
                    r_state <= S_SEND;
                end

                S_SEND: begin
                    // Data and valid stay untouched until the handshake.
                    if (tx_data_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // At least one idle cycle between bytes gives uart_tx
                    // time to drop ready after accepting a byte.
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                    end else if (tx_data_ready) begin
                        r_idx   <= w_idx_inc;
                        r_data  <= w_next_byte;
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b1;
                    r_count <= r_count + 16'd1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Requests arriving while a message is in progress.
            if (r_state != S_IDLE && w_req) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign tx_data       = r_data;
    assign tx_data_valid = r_valid;
    assign busy          = r_busy;
    assign msg_done      = r_done;
    assign overrun       = r_overrun;
    assign msg_count     = r_count;

endmodule

// File: tb/tb_uart_msg_streamer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for uart_msg_streamer (default template, 100-cycle
// period). Expected message contents come from a string-level model of the
// template with the hex field substituted; expected timing comes from the
// documented request-to-output latencies.
// ---------------------------------------------------------------------------
module tb_uart_msg_streamer;

    localparam int PERIOD = 100;
    localparam int LEN    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        periodic_en = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        tx_data_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        busy;
    logic        msg_done;
    logic        overrun;
    logic [15:0] msg_count;

    int n_tests = 0;
    int n_fail = 0;
    int exp_count = 0;
    int cyc = 0;

    uart_msg_streamer #(
        .PERIOD_CYCLES (PERIOD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .periodic_en   (periodic_en),
        .trigger       (trigger),
        .value         (value),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .busy          (busy),
        .msg_done      (msg_done),
        .overrun       (overrun),
        .msg_count     (msg_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Passive recorder, sampled on the falling edge
    // -----------------------------------------------------------------------
    logic [7:0] q_bytes [$];
    int         rise_cyc [$];
    int         done_cyc [$];
    int         busy_rise [$];
    int         stab_err = 0;
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_busy  = 1'b0;
    logic [7:0] p_data  = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_data_valid && tx_data_ready) q_bytes.push_back(tx_data);
            if (tx_data_valid && !p_valid) rise_cyc.push_back(cyc);
            if (p_valid && !p_ready && (!tx_data_valid || tx_data != p_data)) stab_err++;
            if (msg_done) done_cyc.push_back(cyc);
            if (busy && !p_busy) busy_rise.push_back(cyc);
            p_valid = tx_data_valid;
            p_ready = tx_data_ready;
            p_busy  = busy;
            p_data  = tx_data;
        end else begin
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_busy  = 1'b0;
            p_data  = 8'h00;
        end
    end

    // -----------------------------------------------------------------------
    // Reference model: template text with the hex field substituted
    // -----------------------------------------------------------------------
    function automatic string exp_msg(input logic [15:0] v);
        string hexs = "0123456789ABCDEF";
        string f = "";
        for (int d = 3; d >= 0; d--) begin
            int n;
            n = int'((v >> (4 * d)) & 16'h000F);
            f = {f, hexs.substr(n, n)};
        end
        return {"Counter 0x", f, "\015\012"};
    endfunction

    // Index of the first byte of the recorded message at 'start' that
    // differs from the model, or -1 when all LEN bytes agree.
    function automatic int msg_diff(input int start, input logic [15:0] v);
        string m;
        m = exp_msg(v);
        for (int i = 0; i < LEN; i++) begin
            if (start + i >= q_bytes.size()) return i;
            if (q_bytes[start + i] != m[i]) return i;
        end
        return -1;
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus utilities
    // -----------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_bytes.delete();
        rise_cyc.delete();
        done_cyc.delete();
        busy_rise.delete();
        stab_err = 0;
    endtask

    task automatic pulse_trigger(output int t_req);
        trigger = 1'b1;
        t_req = cyc;
        step(1);
        trigger = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        int k = 0;
        while (done_cyc.size() < target && k < budget) begin
            step(1);
            k++;
        end
        ok = (done_cyc.size() >= target);
    endtask

    task automatic wait_bytes(input int target, input int budget, output bit ok);
        int k = 0;
        while (q_bytes.size() < target && k < budget) begin
            step(1);
            k++;
        end
        ok = (q_bytes.size() >= target);
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        n_tests++; if (tx_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", tx_data_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (msg_done !== 1'b0) begin n_fail++; $display("FAIL reset_msg_done got=%b exp=0", msg_done); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        n_tests++; if (msg_count !== 16'h0000) begin n_fail++; $display("FAIL reset_msg_count got=%0d exp=0", msg_count); end
        rst_n = 1'b1;
        clear_mon();
        step(10);
        n_tests++; if (rise_cyc.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle valid_rises=%0d busy=%b exp 0/0", rise_cyc.size(), busy); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_periodic();
        int  t0;
        bit  ok;
        clear_mon();
        value = 16'hBEEF;
        tx_data_ready = 1'b1;
        periodic_en = 1'b1;
        t0 = cyc;
        wait_done(1, 3 * PERIOD, ok);
        exp_count++;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL periodic_first_done got=timeout exp=done"); end
        n_tests++; if (ok && done_cyc[0] != t0 + PERIOD - 1 + 35) begin n_fail++; $display("FAIL periodic_done_cycle got=%0d exp=%0d", ok ? done_cyc[0] - t0 : -1, PERIOD + 34); end
        n_tests++; if (msg_diff(0, 16'hBEEF) != -1) begin n_fail++; $display("FAIL periodic_bytes first bad index=%0d exp=-1", msg_diff(0, 16'hBEEF)); end
        n_tests++; if (msg_count !== 16'(exp_count)) begin n_fail++; $display("FAIL periodic_count got=%0d exp=%0d", msg_count, exp_count); end
        wait_done(2, 3 * PERIOD, ok);
        exp_count++;
        periodic_en = 1'b0;
        n_tests++; if (!ok || done_cyc[1] - done_cyc[0] != PERIOD) begin n_fail++; $display("FAIL periodic_interval got=%0d exp=%0d", ok ? done_cyc[1] - done_cyc[0] : -1, PERIOD); end
        n_tests++; if (q_bytes.size() != 2 * LEN || msg_diff(LEN, 16'hBEEF) != -1) begin n_fail++; $display("FAIL periodic_second_msg bytes=%0d bad_index=%0d exp=%0d/-1", q_bytes.size(), msg_diff(LEN, 16'hBEEF), 2 * LEN); end
        step(5);
        $display("[TB] test_periodic done, messages=%0d", done_cyc.size());
    endtask

    task automatic test_trigger_latency();
        int  t0;
        int  r0;
        int  b0;
        bit  ok;
        logic [31:0] field;
        clear_mon();
        value = 16'h09A0;
        pulse_trigger(t0);
        wait_done(1, 100, ok);
        exp_count++;
        r0 = (rise_cyc.size() > 0) ? rise_cyc[0] - t0 : -1;
        b0 = (busy_rise.size() > 0) ? busy_rise[0] - t0 : -1;
        n_tests++; if (b0 != 1) begin n_fail++; $display("FAIL trig_busy_latency got=%0d exp=1", b0); end
        n_tests++; if (r0 != 2) begin n_fail++; $display("FAIL trig_valid_latency got=%0d exp=2", r0); end
        n_tests++; if (!ok || done_cyc[0] - t0 != 35) begin n_fail++; $display("FAIL trig_done_latency got=%0d exp=35", ok ? done_cyc[0] - t0 : -1); end
        field = (q_bytes.size() >= 14) ? {q_bytes[10], q_bytes[11], q_bytes[12], q_bytes[13]} : 32'h0;
        n_tests++; if (field !== 32'h30394130) begin n_fail++; $display("FAIL trig_field got=%h exp=30394130", field); end
        n_tests++; if (msg_diff(0, 16'h09A0) != -1 || q_bytes.size() != LEN) begin n_fail++; $display("FAIL trig_bytes bad_index=%0d count=%0d exp=-1/%0d", msg_diff(0, 16'h09A0), q_bytes.size(), LEN); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL trig_busy_after got=%b exp=0", busy); end
        $display("[TB] test_trigger_latency done, t_done=%0d", ok ? done_cyc[0] - t0 : -1);
    endtask

    task automatic test_coincident();
        int  t0;
        int  tr;
        bit  ok;
        clear_mon();
        value = 16'h5A5A;
        periodic_en = 1'b1;
        t0 = cyc;
        step(PERIOD - 1);
        pulse_trigger(tr);
        periodic_en = 1'b0;
        wait_done(1, 100, ok);
        exp_count++;
        step(60);
        n_tests++; if (tr != t0 + PERIOD - 1) begin n_fail++; $display("FAIL coinc_alignment got=%0d exp=%0d", tr - t0, PERIOD - 1); end
        n_tests++; if (done_cyc.size() != 1 || q_bytes.size() != LEN) begin n_fail++; $display("FAIL coinc_single_msg msgs=%0d bytes=%0d exp=1/%0d", done_cyc.size(), q_bytes.size(), LEN); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL coinc_overrun got=%b exp=0", overrun); end
        $display("[TB] test_coincident done, messages=%0d", done_cyc.size());
    endtask

    task automatic test_stalls();
        int          t0;
        int          k = 0;
        int          stall = 0;
        int          held = 0;
        bit          forced;
        logic [15:0] v;
        clear_mon();
        v = 16'($urandom);
        value = v;
        pulse_trigger(t0);
        while (done_cyc.size() < 1 && k < 800) begin
            forced = 1'b0;
            if ((stall > 0 && stall < 7) || (stall == 0 && q_bytes.size() == 3 && tx_data_valid)) begin
                tx_data_ready = 1'b0;
                stall++;
                forced = 1'b1;
            end else begin
                tx_data_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (forced && tx_data_valid && q_bytes.size() == 3) held++;
            @(posedge clk);
            #1;
            k++;
        end
        tx_data_ready = 1'b1;
        exp_count++;
        n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL stall_done got=%0d exp=1", done_cyc.size()); end
        n_tests++; if (held != 7) begin n_fail++; $display("FAIL stall_valid_held got=%0d exp=7", held); end
        n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stability violations=%0d exp=0", stab_err); end
        n_tests++; if (q_bytes.size() != LEN || msg_diff(0, v) != -1) begin n_fail++; $display("FAIL stall_bytes count=%0d bad_index=%0d exp=%0d/-1", q_bytes.size(), msg_diff(0, v), LEN); end
        $display("[TB] test_stalls done, value=%h", v);
    endtask

    task automatic test_value_snapshot();
        int  t0;
        bit  ok;
        clear_mon();
        value = 16'h1234;
        pulse_trigger(t0);
        wait_bytes(6, 100, ok);
        value = 16'hFFFF;
        wait_done(1, 100, ok);
        exp_count++;
        n_tests++; if (!ok || msg_diff(0, 16'h1234) != -1) begin n_fail++; $display("FAIL snap_first bad_index=%0d exp=-1", msg_diff(0, 16'h1234)); end
        step(2);
        pulse_trigger(t0);
        wait_done(2, 100, ok);
        exp_count++;
        n_tests++; if (!ok || msg_diff(LEN, 16'hFFFF) != -1) begin n_fail++; $display("FAIL snap_second bad_index=%0d exp=-1", msg_diff(LEN, 16'hFFFF)); end
        $display("[TB] test_value_snapshot done");
    endtask

    task automatic test_random();
        int          t0;
        int          k;
        logic [15:0] v;
        for (int it = 0; it < 8; it++) begin
            clear_mon();
            v = 16'($urandom);
            value = v;
            pulse_trigger(t0);
            k = 0;
            while (done_cyc.size() < 1 && k < 800) begin
                tx_data_ready = ($urandom_range(0, 2) != 0);
                if (q_bytes.size() > 0) value = 16'($urandom);
                step(1);
                k++;
            end
            tx_data_ready = 1'b1;
            exp_count++;
            n_tests++; if (done_cyc.size() != 1 || q_bytes.size() != LEN || msg_diff(0, v) != -1) begin n_fail++; $display("FAIL random_msg it=%0d value=%h msgs=%0d bytes=%0d bad_index=%0d", it, v, done_cyc.size(), q_bytes.size(), msg_diff(0, v)); end
            n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL random_stability it=%0d violations=%0d exp=0", it, stab_err); end
            n_tests++; if (msg_count !== 16'(exp_count)) begin n_fail++; $display("FAIL random_count it=%0d got=%0d exp=%0d", it, msg_count, exp_count); end
            $display("[TB] test_random it=%0d value=%h bytes=%0d", it, v, q_bytes.size());
            step(2);
        end
    endtask

    task automatic test_pending_overrun();
        int          t0;
        bit          ok;
        int          gap;
        logic [15:0] v;
        clear_mon();
        v = 16'($urandom);
        value = v;
        pulse_trigger(t0);
        wait_bytes(5, 100, ok);
        pulse_trigger(t0);
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL pend_no_overrun got=%b exp=0", overrun); end
        wait_bytes(8, 100, ok);
        pulse_trigger(t0);
        step(1);
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL pend_overrun got=%b exp=1", overrun); end
        wait_done(2, 200, ok);
        step(80);
        exp_count += 2;
        gap = (busy_rise.size() > 1 && done_cyc.size() > 0) ? busy_rise[1] - done_cyc[0] : -1;
        n_tests++; if (done_cyc.size() != 2 || q_bytes.size() != 2 * LEN) begin n_fail++; $display("FAIL pend_msg_total msgs=%0d bytes=%0d exp=2/%0d", done_cyc.size(), q_bytes.size(), 2 * LEN); end
        n_tests++; if (gap != 1) begin n_fail++; $display("FAIL pend_restart_gap got=%0d exp=1", gap); end
        n_tests++; if (msg_diff(0, v) != -1 || msg_diff(LEN, v) != -1) begin n_fail++; $display("FAIL pend_bytes bad_index=%0d/%0d exp=-1/-1", msg_diff(0, v), msg_diff(LEN, v)); end
        n_tests++; if (overrun !== 1'b1 || msg_count !== 16'(exp_count)) begin n_fail++; $display("FAIL pend_sticky overrun=%b count=%0d exp=1/%0d", overrun, msg_count, exp_count); end
        $display("[TB] test_pending_overrun done, messages=%0d", done_cyc.size());
    endtask

    task automatic test_async_reset();
        int  t0;
        bit  ok;
        clear_mon();
        value = 16'($urandom);
        pulse_trigger(t0);
        wait_bytes(8, 100, ok);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (tx_data !== 8'h00 || tx_data_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_datapath data=%h valid=%b busy=%b exp=00/0/0", tx_data, tx_data_valid, busy); end
        n_tests++; if (msg_done !== 1'b0 || overrun !== 1'b0 || msg_count !== 16'h0000) begin n_fail++; $display("FAIL arst_status done=%b overrun=%b count=%0d exp=0/0/0", msg_done, overrun, msg_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_count = 0;
        clear_mon();
        step(150);
        n_tests++; if (rise_cyc.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_quiet rises=%0d dones=%0d busy=%b exp=0/0/0", rise_cyc.size(), done_cyc.size(), busy); end
        n_tests++; if (msg_count !== 16'h0000) begin n_fail++; $display("FAIL arst_count got=%0d exp=0", msg_count); end
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_after_reset();
        int          t0;
        bit          ok;
        logic [15:0] v;
        clear_mon();
        v = 16'($urandom);
        value = v;
        pulse_trigger(t0);
        wait_done(1, 100, ok);
        exp_count++;
        n_tests++; if (!ok || msg_diff(0, v) != -1) begin n_fail++; $display("FAIL post_reset_msg bad_index=%0d exp=-1", msg_diff(0, v)); end
        n_tests++; if (msg_count !== 16'(exp_count)) begin n_fail++; $display("FAIL post_reset_count got=%0d exp=%0d", msg_count, exp_count); end
        $display("[TB] test_after_reset done, value=%h", v);
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_trigger_latency();
        test_coincident();
        test_stalls();
        test_value_snapshot();
        test_random();
        test_pending_overrun();
        test_async_reset();
        test_after_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
